// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver. Frame format is start(0),
//                D_WIDTH data bits LSB first, optional parity, stop(1).
//                The line idles high. CLK runs at PRESCALE x baud.
//                Each bit is decided at edge count S+1, where S = PRESCALE/2-1.
//                Optional macro UART_RX_MAJORITY_VOTE_EN: when defined, each
//                bit is the 2-of-3 majority of the samples at S-1, S and S+1.
//                When undefined, each bit is the single sample at S.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int D_WIDTH  = 8,
    parameter int PRESCALE = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    output logic [D_WIDTH-1:0] P_DATA,
    output logic               DATA_VALID,
    output logic               PAR_ERR,
    output logic               STP_ERR
);

    localparam int C_S    = PRESCALE / 2 - 1;
    localparam int C_EC_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int C_BC_W = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;

    localparam logic [C_EC_W-1:0] C_EC_LAST = C_EC_W'(PRESCALE - 1);
    localparam logic [C_EC_W-1:0] C_EC_MID  = C_EC_W'(C_S);
    localparam logic [C_EC_W-1:0] C_EC_DEC  = C_EC_W'(C_S + 1);
    localparam logic [C_BC_W-1:0] C_BC_LAST = C_BC_W'(D_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [C_EC_W-1:0]    ec_q, ec_d;
    logic [C_BC_W-1:0]    bc_q, bc_d;
    logic [D_WIDTH-1:0]   shift_q, shift_d;
    logic [D_WIDTH-1:0]   pdata_q, pdata_d;
    logic                 pen_q, pen_d;
    logic                 ptyp_q, ptyp_d;
    logic                 perr_q, perr_d;
    logic                 dv_q, dv_d;
    logic                 pe_q, pe_d;
    logic                 se_q, se_d;

    logic                 sync1_q, sync2_q, rxd_q;
    logic                 rx_s;
    logic                 bit_val;

    assign rx_s = sync2_q;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            rxd_q   <= 1'b1;
        end else begin
            sync1_q <= RX_IN;
            sync2_q <= sync1_q;
            rxd_q   <= sync2_q;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [C_EC_W-1:0] C_EC_PRE = C_EC_W'(C_S - 1);
    logic early_q, mid_q;

    // Capture the two samples before the decision cycle; the third is live rx_s.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            early_q <= 1'b1;
            mid_q   <= 1'b1;
        end else begin
            if (ec_q == C_EC_PRE) early_q <= rx_s;
            if (ec_q == C_EC_MID) mid_q   <= rx_s;
        end
    end

    assign bit_val = (early_q & mid_q) | (early_q & rx_s) | (mid_q & rx_s);
`else
    logic mid_q;

    // Capture the mid-bit sample; it is consumed one cycle later.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mid_q <= 1'b1;
        end else if (ec_q == C_EC_MID) begin
            mid_q <= rx_s;
        end
    end

    assign bit_val = mid_q;
`endif

    // State, counters, datapath and registered output strobes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            ec_q    <= '0;
            bc_q    <= '0;
            shift_q <= '0;
            pdata_q <= '0;
            pen_q   <= 1'b0;
            ptyp_q  <= 1'b0;
            perr_q  <= 1'b0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ec_q    <= ec_d;
            bc_q    <= bc_d;
            shift_q <= shift_d;
            pdata_q <= pdata_d;
            pen_q   <= pen_d;
            ptyp_q  <= ptyp_d;
            perr_q  <= perr_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            se_q    <= se_d;
        end
    end

    // Next-state logic: bit timing, frame sequencing and end-of-frame verdict.
    always_comb begin
        state_d = state_q;
        ec_d    = ec_q;
        bc_d    = bc_q;
        shift_d = shift_q;
        pdata_d = pdata_q;
        pen_d   = pen_q;
        ptyp_d  = ptyp_q;
        perr_d  = perr_q;
        dv_d    = 1'b0;
        pe_d    = 1'b0;
        se_d    = 1'b0;

        if (ec_q == C_EC_LAST) begin
            ec_d = '0;
        end else begin
            ec_d = ec_q + C_EC_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                ec_d = '0;
                bc_d = '0;
                // Only a true 1->0 transition starts a frame, so a line
                // stuck low cannot retrigger. The edge cycle itself is ec=0.
                if (rxd_q && !rx_s) begin
                    state_d = S_START;
                    ec_d    = C_EC_W'(1);
                    pen_d   = PAR_EN;
                    ptyp_d  = PAR_TYP;
                    perr_d  = 1'b0;
                end
            end
            S_START: begin
                if ((ec_q == C_EC_DEC) && bit_val) begin
                    state_d = S_IDLE;
                    ec_d    = '0;
                end else if (ec_q == C_EC_LAST) begin
                    state_d = S_DATA;
                    bc_d    = '0;
                end
            end
            S_DATA: begin
                if (ec_q == C_EC_DEC) begin
                    shift_d[bc_q] = bit_val;
                end
                if (ec_q == C_EC_LAST) begin
                    if (bc_q == C_BC_LAST) begin
                        state_d = pen_q ? S_PARITY : S_STOP;
                    end else begin
                        bc_d = bc_q + C_BC_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if ((ec_q == C_EC_DEC) && (bit_val != ((^shift_q) ^ ptyp_q))) begin
                    perr_d = 1'b1;
                end
                if (ec_q == C_EC_LAST) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Verdict at mid-stop; returning to IDLE here lets a start
                // edge that follows immediately after the stop bit be caught.
                if (ec_q == C_EC_DEC) begin
                    state_d = S_IDLE;
                    ec_d    = '0;
                    if (!bit_val) begin
                        se_d = 1'b1;
                    end else if (perr_q) begin
                        pe_d = 1'b1;
                    end else begin
                        dv_d    = 1'b1;
                        pdata_d = shift_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                ec_d    = '0;
            end
        endcase
    end

    assign P_DATA     = pdata_q;
    assign DATA_VALID = dv_q;
    assign PAR_ERR    = pe_q;
    assign STP_ERR    = se_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. The whole line waveform is
//                built up front, a frame-level model derives the expected
//                outputs for every cycle, then the waveform is replayed.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int D    = 8;
    localparam int P    = 8;
    localparam int S    = P / 2 - 1;
    localparam int NMAX = 8192;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         RX_IN = 1'b1;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic [D-1:0] P_DATA;
    logic         DATA_VALID;
    logic         PAR_ERR;
    logic         STP_ERR;

    uart_rx #(.D_WIDTH(D), .PRESCALE(P)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    // Stimulus, indexed by the rising edge that samples it.
    bit         wave  [NMAX];
    bit         rst_w [NMAX];
    bit         pen_w [NMAX];
    bit         pt_w  [NMAX];
    // Synchronized line as seen by the receiver in each cycle.
    bit         rs    [NMAX];
    // Model events and per-cycle expectations.
    bit         ev_dv [NMAX];
    bit         ev_pe [NMAX];
    bit         ev_se [NMAX];
    logic [7:0] ev_d  [NMAX];
    bit         exp_dv[NMAX];
    bit         exp_pe[NMAX];
    bit         exp_se[NMAX];
    logic [7:0] exp_pd[NMAX];
    bit         obs_dv[NMAX];
    logic [7:0] obs_pd[NMAX];

    int n_cyc = 0;
    int wp = 0;
    bit cur_pen = 1'b0;
    bit cur_pt = 1'b0;
    bit model_ready = 1'b0;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, req);
        end
    endtask

    task automatic put(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            if (wp < NMAX) begin
                wave[wp]  = v;
                pen_w[wp] = cur_pen;
                pt_w[wp]  = cur_pt;
                rst_w[wp] = 1'b0;
                wp++;
            end
        end
    endtask

    task automatic frame(input logic [7:0] d, input bit pen, input bit pt,
                         input bit flip_par, input bit stopv, output int w0);
        cur_pen = pen;
        cur_pt  = pt;
        w0 = wp;
        put(1'b0, P);
        for (int i = 0; i < D; i++) put(d[i], P);
        if (pen) put((^d) ^ pt ^ flip_par, P);
        put(stopv, P);
    endtask

    // Value the receiver assigns to bit k of a frame whose start edge is cycle t.
    function automatic bit bitval(input int t, input int k);
        int b;
        b = t + k * P + S;
`ifdef UART_RX_MAJORITY_VOTE_EN
        return (rs[b-1] & rs[b]) | (rs[b-1] & rs[b+1]) | (rs[b] & rs[b+1]);
`else
        return rs[b];
`endif
    endfunction

    // Frame-level reference: scan for start edges and judge each frame.
    task automatic run_model();
        int j, t, dl, ks, kind;
        bit pen, pt, perr, abort;
        logic [7:0] d;
        logic [7:0] pd;
        bit orst;
        for (int m = 0; m < n_cyc; m++) begin
            rs[m] = (m == 0 || rst_w[m] || rst_w[m-1]) ? 1'b1 : wave[m-1];
            ev_dv[m] = 1'b0; ev_pe[m] = 1'b0; ev_se[m] = 1'b0; ev_d[m] = 8'h00;
        end
        j = 1;
        while (j < n_cyc) begin
            if (!rst_w[j] && rs[j-1] && !rs[j] && (j + 12 * P < n_cyc)) begin
                t = j;
                pen = pen_w[t+1];
                pt  = pt_w[t+1];
                d = 8'h00;
                kind = 0;
                if (bitval(t, 0)) begin
                    dl = t + S + 1;
                end else begin
                    for (int i = 0; i < D; i++) d[i] = bitval(t, 1 + i);
                    ks = 1 + D + int'(pen);
                    perr = pen && (bitval(t, 1 + D) != ((^d) ^ pt));
                    dl = t + ks * P + S + 1;
                    if (!bitval(t, ks)) kind = 3;
                    else if (perr)      kind = 2;
                    else                kind = 1;
                end
                abort = 1'b0;
                for (int m = t; m <= dl + 1; m++) begin
                    if (rst_w[m] && !abort) begin
                        abort = 1'b1;
                        j = m;
                    end
                end
                if (!abort) begin
                    if (kind == 1) begin ev_dv[dl+1] = 1'b1; ev_d[dl+1] = d; end
                    if (kind == 2) ev_pe[dl+1] = 1'b1;
                    if (kind == 3) ev_se[dl+1] = 1'b1;
                    j = dl + 1;
                end
            end else begin
                j++;
            end
        end
        pd = 8'h00;
        for (int m = 0; m < n_cyc - 1; m++) begin
            if (rst_w[m])      pd = 8'h00;
            else if (ev_dv[m]) pd = ev_d[m];
            orst = rst_w[m] || rst_w[m+1];
            exp_dv[m] = ev_dv[m] && !orst;
            exp_pe[m] = ev_pe[m] && !orst;
            exp_se[m] = ev_se[m] && !orst;
            exp_pd[m] = orst ? 8'h00 : pd;
        end
    endtask

    function automatic int strobes_in(input int a, input int b);
        int n;
        n = 0;
        for (int m = a; m <= b; m++) n += int'(exp_dv[m]) + int'(exp_pe[m]) + int'(exp_se[m]);
        return n;
    endfunction

    // Compare every cycle against the model (cycle j is observed after rising edge j).
    initial begin : compare
        int cyc;
        cyc = 0;
        forever begin
            @(negedge CLK);
            if (model_ready && cyc < n_cyc - 1) begin
                obs_dv[cyc] = DATA_VALID;
                obs_pd[cyc] = P_DATA;
                chk("DATA_VALID", cyc, 32'(DATA_VALID), 32'(exp_dv[cyc]));
                chk("PAR_ERR",    cyc, 32'(PAR_ERR),    32'(exp_pe[cyc]));
                chk("STP_ERR",    cyc, 32'(STP_ERR),    32'(exp_se[cyc]));
                chk("P_DATA",     cyc, 32'(P_DATA),     32'(exp_pd[cyc]));
            end
            cyc++;
        end
    end

    initial begin : main
        int w_a5, w_0f, w_0fb, w_3c, w_11, w_gl, w_55, w_aa, w_f0, w_81, w_96, rst_at;
        int w0, gap;
        logic [7:0] rd;
        bit rpen, rpt, rfp, rsv;

        // Power-on reset then directed scenarios.
        put(1'b1, 4);
        for (int m = 0; m < 4; m++) rst_w[m] = 1'b1;
        put(1'b1, 10);
        frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, w_a5);  put(1'b1, 12);
        frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, w_0f);  put(1'b1, 12);
        frame(8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, w_0fb); put(1'b1, 12);
        frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, w_3c);  put(1'b0, 40); put(1'b1, 12);
        frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, w_11);  put(1'b1, 12);
        w_gl = wp; put(1'b0, 2); put(1'b1, 20);
        frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, w_55);
        frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, w_aa);  put(1'b1, 12);
        frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, w_f0);  put(1'b1, 12);
        rst_at = w_f0 + 6 * P + 2;
        for (int m = 0; m < 3; m++) rst_w[rst_at + m] = 1'b1;
        frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, w_81);  put(1'b1, 12);
        frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, w_96);
        for (int i = 0; i < D; i++) wave[w_96 + (1 + i) * P + S] = ~wave[w_96 + (1 + i) * P + S];
        put(1'b1, 12);

        // Randomized frames: errors, mid-frame config changes, spikes, glitches.
        for (int f = 0; f < 40; f++) begin
            rd   = 8'($urandom);
            rpen = 1'($urandom_range(0, 1));
            rpt  = 1'($urandom_range(0, 1));
            rfp  = ($urandom_range(0, 9) == 0);
            rsv  = ($urandom_range(0, 9) != 0);
            frame(rd, rpen, rpt, rfp, rsv, w0);
            if ($urandom_range(0, 3) == 0) begin
                for (int m = w0 + 2 * P; m < wp; m++) begin
                    pen_w[m] = ~pen_w[m];
                    pt_w[m]  = ~pt_w[m];
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                wave[w0 + P + int'($urandom_range(0, 9 * P - 1))] ^= 1'b1;
            end
            gap = int'($urandom_range(0, 15));
            put(1'b1, gap);
            if ($urandom_range(0, 4) == 0) begin
                put(1'b0, int'($urandom_range(1, 3)));
                put(1'b1, int'($urandom_range(4, 10)));
            end
        end
        put(1'b1, 200);
        n_cyc = wp;

        run_model();

        // Hand-computed anchors for the model.
        chk("model_a5_valid",   w_a5 + 78,  32'(exp_dv[w_a5 + 78]),  32'd1);
        chk("model_a5_data",    w_a5 + 78,  32'(exp_pd[w_a5 + 78]),  32'hA5);
        chk("model_0f_valid",   w_0f + 86,  32'(exp_dv[w_0f + 86]),  32'd1);
        chk("model_0f_data",    w_0f + 86,  32'(exp_pd[w_0f + 86]),  32'h0F);
        chk("model_par_err",    w_0fb + 86, 32'(exp_pe[w_0fb + 86]), 32'd1);
        chk("model_par_hold",   w_0fb + 86, 32'(exp_pd[w_0fb + 86]), 32'h0F);
        chk("model_stp_err",    w_3c + 78,  32'(exp_se[w_3c + 78]),  32'd1);
        chk("model_low_quiet",  w_3c + 79,  32'(strobes_in(w_3c + 79, w_11 + 1)), 32'd0);
        chk("model_11_data",    w_11 + 78,  32'(exp_pd[w_11 + 78]),  32'h11);
        chk("model_glitch",     w_gl,       32'(strobes_in(w_gl, w_55 + 1)), 32'd0);
        chk("model_b2b_first",  w_55 + 78,  32'(exp_dv[w_55 + 78]),  32'd1);
        chk("model_b2b_second", w_aa + 78,  32'(exp_dv[w_aa + 78]),  32'd1);
        chk("model_rst_clear",  rst_at,     32'(exp_pd[rst_at]),     32'h00);
        chk("model_81_data",    w_81 + 78,  32'(exp_pd[w_81 + 78]),  32'h81);
`ifdef UART_RX_MAJORITY_VOTE_EN
        chk("model_spike_data", w_96 + 78,  32'(exp_pd[w_96 + 78]),  32'h96);
`else
        chk("model_spike_data", w_96 + 78,  32'(exp_pd[w_96 + 78]),  32'h69);
`endif
        model_ready = 1'b1;

        // Replay: inputs for rising edge k are applied 2 time units after edge k-1.
        for (int k = 0; k < n_cyc; k++) begin
            if (k > 0) begin
                @(posedge CLK);
                #2;
            end
            RX_IN   = wave[k];
            PAR_EN  = pen_w[k];
            PAR_TYP = pt_w[k];
            RST     = ~rst_w[k];
            if (k > 10 && rst_w[k] && !rst_w[k-1]) begin
                #1;
                chk("async_rst_P_DATA", k, 32'(P_DATA), 32'h00);
                chk("async_rst_strobes", k, 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'd0);
            end
        end
        repeat (3) @(posedge CLK);
        #6;

        // A few direct observations of the DUT at the anchored cycles.
        chk("dut_a5_valid",   w_a5 + 78, 32'(obs_dv[w_a5 + 78]), 32'd1);
        chk("dut_a5_data",    w_a5 + 78, 32'(obs_pd[w_a5 + 78]), 32'hA5);
        chk("dut_b2b_first",  w_55 + 78, 32'(obs_dv[w_55 + 78]), 32'd1);
        chk("dut_b2b_second", w_aa + 78, 32'(obs_dv[w_aa + 78]), 32'd1);
        chk("dut_81_data",    w_81 + 78, 32'(obs_pd[w_81 + 78]), 32'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver; the receive-side counterpart of the team's UART transmitter. Uses the same frame format: start(0), D_WIDTH data bits LSB first, optional parity, stop(1); the line idles high.
- Runs on a CLK at PRESCALE × baud rate. Synchronizes RX_IN, detects the start edge, samples each bit at mid-bit, checks parity and stop, and presents the parallel word with a one-cycle valid strobe.

Parameters:
- D_WIDTH, 8, number of data bits per frame.
- PRESCALE, 8, CLK cycles per bit. Must be even and ≥4. Mid-sample index S = PRESCALE/2 − 1.

Ports:
- CLK  input  1  receiver clock, PRESCALE × baud.
- RST  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line, asynchronous to CLK, idles high.
- PAR_EN  input  1  1 = frame contains a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity (same convention as the transmitter).
- P_DATA  output  D_WIDTH  last correctly received word.
- DATA_VALID  output  1  one-cycle strobe; P_DATA is new.
- PAR_ERR  output  1  one-cycle strobe; parity mismatch, frame discarded.
- STP_ERR  output  1  one-cycle strobe; stop bit sampled 0, frame discarded.

Behaviour:
- Reset (RST=0, async):
  - FSM → IDLE; all counters 0.
  - P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0; synchronizer flops=1.
  - Reset mid-frame abandons the frame with no strobe.
- Synchronizer: RX_IN passes through 2 flops; everything below uses the synchronized value rx_s and its previous value rx_d.
- Edge counter ec runs 0..PRESCALE−1 and wraps; the wrap advances to the next bit.
- Decision cycle for every bit is ec = S+1 (same in both optional-feature modes).
- IDLE:
  - Start detected when rx_d=1 and rx_s=0 (falling edge only); that cycle is ec=0 → START.
  - PAR_EN and PAR_TYP are latched at this edge; mid-frame changes are ignored.
  - A line held low never retriggers.
- START: at the decision cycle, sampled bit 1 → false start, → IDLE, no strobes. Sampled 0 → continue; at the wrap → DATA, bit counter bc=0.
- DATA:
  - Sampled bit shifts into shift register position bc (LSB first).
  - After bit D_WIDTH−1 wraps → PARITY if the latched PAR_EN=1, else → STOP.
- PARITY: expected bit = XOR(data) XOR PAR_TYP. A mismatch sets an internal error flag; the FSM always continues to STOP at the wrap.
- STOP, at the decision cycle (no wait for the wrap):
  - Sample 0 → STP_ERR=1 for the next cycle.
  - Sample 1 with parity error → PAR_ERR=1 for the next cycle.
  - Sample 1, no error → P_DATA ← shift register and DATA_VALID=1 for the next cycle.
  - The FSM returns to IDLE in the same cycle, so a start edge arriving right after mid-stop is caught.
  - STP_ERR takes priority; only one strobe fires per frame.
- Strobes are registered and high exactly one cycle. P_DATA changes only on a good frame and holds otherwise.
- Latency: with ec=0 as the first low rx_s cycle, DATA_VALID is high on cycle (1+D_WIDTH+P)·PRESCALE + S + 2, where P = latched PAR_EN.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
  - Defined: each bit value is the 2-of-3 majority of rx_s at ec = S−1, S, S+1.
  - Undefined: each bit value is the single rx_s sample at ec = S.
- Decision timing, states and latency are identical in both builds.

Test Plan:
- PRESCALE=8, PAR_EN=0, frame 0xA5, idle high between frames → DATA_VALID pulse on cycle 8·9+5=77 after start; P_DATA=0xA5; no error strobes.
- PAR_EN=1, PAR_TYP=0, 0x0F with correct parity bit 0 → DATA_VALID, P_DATA=0x0F. Same frame with parity bit 1 → PAR_ERR pulse on cycle 85; P_DATA keeps its old value.
- Frame 0x3C with stop bit forced 0 → STP_ERR one cycle, no DATA_VALID. Line then held low for 40 cycles → no further strobes; next good frame 0x11 → P_DATA=0x11.
- 2-cycle low glitch on the idle line → false start, no strobes. Back-to-back frames 0x55 then 0xAA with zero idle gap → two DATA_VALID pulses exactly 80 cycles apart.
- RST pulsed low mid-data → all outputs 0 immediately; next frame 0x81 received correctly.
- With UART_RX_MAJORITY_VOTE_EN defined: a 1-cycle inverted spike at ec=S in each data bit of 0x96 → still P_DATA=0x96. Same stimulus with the macro undefined → corrupted word (or parity error when PAR_EN=1).
